// File: rtl/writeback_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_regfile_if
//  Description : Bundle of the writeback, issue, read-port and scoreboard
//                status signals that connect the NAND CPU pipeline to the
//                architectural register file.
//                  master : pipeline side (drives writeback/issue/read addrs)
//                  slave  : register file side (returns read data/status)
//                Ports carried:
//                  wb_valid, wb_use_rw, wb_rw_addr[3:0], wb_data[15:0],
//                  wb_write_ps, wb_ps          writeback bundle
//                  ra_addr[3:0], rt_addr[3:0]  read addresses
//                  ra[15:0], rt[15:0], ps      bypassed read data
//                  iss_valid, iss_use_rw, iss_rw_addr[3:0], iss_write_ps
//                                              issue-side scoreboard update
//                  ra_busy, rt_busy, ps_busy   outstanding-write status
//                  sb_overflow, sb_underflow   sticky scoreboard errors
//  Revision    : 1.0 - initial release
// ============================================================================
interface writeback_regfile_if;
    // Writeback bundle
    logic        wb_valid;
    logic        wb_use_rw;
    logic [3:0]  wb_rw_addr;
    logic [15:0] wb_data;
    logic        wb_write_ps;
    logic        wb_ps;

    // Read ports
    logic [3:0]  ra_addr;
    logic [3:0]  rt_addr;
    logic [15:0] ra;
    logic [15:0] rt;
    logic        ps;

    // Issue side of the scoreboard
    logic        iss_valid;
    logic        iss_use_rw;
    logic [3:0]  iss_rw_addr;
    logic        iss_write_ps;

    // Scoreboard status
    logic        ra_busy;
    logic        rt_busy;
    logic        ps_busy;
    logic        sb_overflow;
    logic        sb_underflow;

    modport master (
        output wb_valid, wb_use_rw, wb_rw_addr, wb_data, wb_write_ps, wb_ps,
        output ra_addr, rt_addr,
        output iss_valid, iss_use_rw, iss_rw_addr, iss_write_ps,
        input  ra, rt, ps,
        input  ra_busy, rt_busy, ps_busy, sb_overflow, sb_underflow
    );

    modport slave (
        input  wb_valid, wb_use_rw, wb_rw_addr, wb_data, wb_write_ps, wb_ps,
        input  ra_addr, rt_addr,
        input  iss_valid, iss_use_rw, iss_rw_addr, iss_write_ps,
        output ra, rt, ps,
        output ra_busy, rt_busy, ps_busy, sb_overflow, sb_underflow
    );
endinterface
`default_nettype wire

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_regfile
//  Description : Architectural register file and writeback receiver for the
//                NAND CPU. Holds sixteen 16-bit general registers and the
//                predicate bit ps, offers two combinational read ports with
//                same-cycle writeback bypass, and keeps a 2-bit outstanding
//                write counter per register (and for ps) so issue logic can
//                detect RAW hazards.
//  Ports       : clk    - clock, all state changes on the rising edge
//                n_rst  - synchronous active-low reset
//                bus    - writeback_regfile_if.slave (writeback bundle, issue
//                         info, read addresses in; read data, busy flags and
//                         sticky scoreboard error flags out)
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_regfile (
    input  wire logic          clk,
    input  wire logic          n_rst,
    writeback_regfile_if.slave bus
);

    localparam int          c_NUM_REGS = 16;
    localparam int          c_DATA_W   = 16;
    localparam int          c_ADDR_W   = 4;
    localparam int          c_CNT_W    = 2;
    localparam logic [1:0]  c_CNT_MAX  = 2'd3;
    localparam logic [1:0]  c_CNT_ONE  = 2'd1;
    localparam logic [1:0]  c_CNT_ZERO = 2'd0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_DATA_W-1:0] r_regs   [c_NUM_REGS];
    logic                r_ps;
    logic [c_CNT_W-1:0]  r_cnt    [c_NUM_REGS];
    logic [c_CNT_W-1:0]  r_ps_cnt;
    logic                r_sb_overflow;
    logic                r_sb_underflow;

    // ------------------------------------------------------------------------
    // Writeback qualification: wb fields only matter while wb_valid is high.
    // ------------------------------------------------------------------------
    logic w_rf_we;
    logic w_ps_we;

    assign w_rf_we = bus.wb_valid & bus.wb_use_rw;
    assign w_ps_we = bus.wb_valid & bus.wb_write_ps;

    // ------------------------------------------------------------------------
    // Scoreboard counter next-state.
    // A simultaneous increment and decrement cancel out, so only a lone
    // increment or a lone decrement moves the counter; both saturate.
    // ------------------------------------------------------------------------
    function automatic logic [c_CNT_W-1:0] f_cnt_next(
        input logic [c_CNT_W-1:0] cnt,
        input logic               inc,
        input logic               dec
    );
        logic [c_CNT_W-1:0] nxt;
        nxt = cnt;
        if (inc && !dec && (cnt != c_CNT_MAX)) begin
            nxt = cnt + c_CNT_ONE;
        end else if (dec && !inc && (cnt != c_CNT_ZERO)) begin
            nxt = cnt - c_CNT_ONE;
        end
        return nxt;
    endfunction

    logic [c_NUM_REGS-1:0] w_inc;
    logic [c_NUM_REGS-1:0] w_dec;
    logic [c_NUM_REGS-1:0] w_ovf_ev;
    logic [c_NUM_REGS-1:0] w_unf_ev;
    logic [c_CNT_W-1:0]    w_cnt_nxt [c_NUM_REGS];

    generate
        for (genvar gi = 0; gi < c_NUM_REGS; gi++) begin : g_sb
            assign w_inc[gi] = bus.iss_valid & bus.iss_use_rw &
                               (bus.iss_rw_addr == c_ADDR_W'(gi));
            assign w_dec[gi] = w_rf_we & (bus.wb_rw_addr == c_ADDR_W'(gi));

            // Error events only fire on an unmatched update at a rail.
            assign w_ovf_ev[gi] = w_inc[gi] & ~w_dec[gi] &
                                  (r_cnt[gi] == c_CNT_MAX);
            assign w_unf_ev[gi] = w_dec[gi] & ~w_inc[gi] &
                                  (r_cnt[gi] == c_CNT_ZERO);

            assign w_cnt_nxt[gi] = f_cnt_next(r_cnt[gi], w_inc[gi], w_dec[gi]);
        end
    endgenerate

    logic               w_ps_inc;
    logic               w_ps_dec;
    logic               w_ps_ovf_ev;
    logic               w_ps_unf_ev;
    logic [c_CNT_W-1:0] w_ps_cnt_nxt;

    assign w_ps_inc     = bus.iss_valid & bus.iss_write_ps;
    assign w_ps_dec     = w_ps_we;
    assign w_ps_ovf_ev  = w_ps_inc & ~w_ps_dec & (r_ps_cnt == c_CNT_MAX);
    assign w_ps_unf_ev  = w_ps_dec & ~w_ps_inc & (r_ps_cnt == c_CNT_ZERO);
    assign w_ps_cnt_nxt = f_cnt_next(r_ps_cnt, w_ps_inc, w_ps_dec);

    logic w_any_ovf;
    logic w_any_unf;

    assign w_any_ovf = (|w_ovf_ev) | w_ps_ovf_ev;
    assign w_any_unf = (|w_unf_ev) | w_ps_unf_ev;

    // ------------------------------------------------------------------------
    // Read ports with zero-cycle bypass of a qualified writeback.
    // ------------------------------------------------------------------------
    logic               w_ra_hit;
    logic               w_rt_hit;
    logic [c_CNT_W-1:0] w_ra_cnt;
    logic [c_CNT_W-1:0] w_rt_cnt;

    assign w_ra_hit = w_rf_we & (bus.wb_rw_addr == bus.ra_addr);
    assign w_rt_hit = w_rf_we & (bus.wb_rw_addr == bus.rt_addr);
    assign w_ra_cnt = r_cnt[bus.ra_addr];
    assign w_rt_cnt = r_cnt[bus.rt_addr];

    assign bus.ra = w_ra_hit ? bus.wb_data : r_regs[bus.ra_addr];
    assign bus.rt = w_rt_hit ? bus.wb_data : r_regs[bus.rt_addr];
    assign bus.ps = w_ps_we  ? bus.wb_ps   : r_ps;

    // Busy comes from registered counters only (issue this cycle is not
    // visible yet). The last pending write, arriving this cycle, is already
    // bypassed onto the read port, so it no longer counts as outstanding.
    assign bus.ra_busy = (w_ra_cnt != c_CNT_ZERO) &
                         ~(w_ra_hit & (w_ra_cnt == c_CNT_ONE));
    assign bus.rt_busy = (w_rt_cnt != c_CNT_ZERO) &
                         ~(w_rt_hit & (w_rt_cnt == c_CNT_ONE));
    assign bus.ps_busy = (r_ps_cnt != c_CNT_ZERO) &
                         ~(w_ps_we & (r_ps_cnt == c_CNT_ONE));

    assign bus.sb_overflow  = r_sb_overflow;
    assign bus.sb_underflow = r_sb_underflow;

    // ------------------------------------------------------------------------
    // State update. Reset drops any writeback/issue presented in its cycle.
    // An underflowing writeback still writes its data.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_ps           <= 1'b0;
            r_ps_cnt       <= '0;
            r_sb_overflow  <= 1'b0;
            r_sb_underflow <= 1'b0;
        end else begin
            if (w_rf_we) begin
                r_regs[bus.wb_rw_addr] <= bus.wb_data;
            end
            if (w_ps_we) begin
                r_ps <= bus.wb_ps;
            end
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_ps_cnt <= w_ps_cnt_nxt;
            if (w_any_ovf) begin
                r_sb_overflow <= 1'b1;
            end
            if (w_any_unf) begin
                r_sb_underflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_regfile
//  Description : Self-checking bench for writeback_regfile. Directed tasks
//                cover reset, bypass, ps, busy tracking and scoreboard error
//                flags; a randomized task compares every output each cycle
//                against a behavioural model of the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    writeback_regfile_if bus ();

    writeback_regfile dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // Behavioural model
    logic [15:0] m_regs [16];
    logic        m_ps;
    int          m_cnt  [16];
    int          m_ps_cnt;
    logic        m_ovf;
    logic        m_unf;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic drive_idle();
        bus.wb_valid     = 1'b0;
        bus.wb_use_rw    = 1'b0;
        bus.wb_rw_addr   = 4'd0;
        bus.wb_data      = 16'h0000;
        bus.wb_write_ps  = 1'b0;
        bus.wb_ps        = 1'b0;
        bus.iss_valid    = 1'b0;
        bus.iss_use_rw   = 1'b0;
        bus.iss_rw_addr  = 4'd0;
        bus.iss_write_ps = 1'b0;
        bus.ra_addr      = 4'd0;
        bus.rt_addr      = 4'd0;
    endtask

    // Apply the rules of one rising edge to the model.
    task automatic model_edge();
        bit wr, pw, iss_r, iss_p, up, down;
        int wa, ia;
        if (!n_rst) begin
            for (int r = 0; r < 16; r++) begin
                m_regs[r] = 16'h0000;
                m_cnt[r]  = 0;
            end
            m_ps = 1'b0; m_ps_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            wr    = bus.wb_valid && bus.wb_use_rw;
            pw    = bus.wb_valid && bus.wb_write_ps;
            iss_r = bus.iss_valid && bus.iss_use_rw;
            iss_p = bus.iss_valid && bus.iss_write_ps;
            wa    = int'(bus.wb_rw_addr);
            ia    = int'(bus.iss_rw_addr);
            if (wr) m_regs[wa] = bus.wb_data;
            if (pw) m_ps = bus.wb_ps;
            for (int r = 0; r < 16; r++) begin
                up   = iss_r && (ia == r);
                down = wr && (wa == r);
                if (up && !down) begin
                    if (m_cnt[r] == 3) m_ovf = 1'b1; else m_cnt[r]++;
                end else if (down && !up) begin
                    if (m_cnt[r] == 0) m_unf = 1'b1; else m_cnt[r]--;
                end
            end
            if (iss_p && !pw) begin
                if (m_ps_cnt == 3) m_ovf = 1'b1; else m_ps_cnt++;
            end else if (pw && !iss_p) begin
                if (m_ps_cnt == 0) m_unf = 1'b1; else m_ps_cnt--;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
    endtask

    task automatic wb_reg(input logic [3:0] a, input logic [15:0] d);
        bus.wb_valid = 1'b1; bus.wb_use_rw = 1'b1;
        bus.wb_rw_addr = a; bus.wb_data = d;
    endtask

    task automatic iss_reg(input logic [3:0] a);
        bus.iss_valid = 1'b1; bus.iss_use_rw = 1'b1; bus.iss_rw_addr = a;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.ra_addr = 4'(i);
            bus.rt_addr = 4'(15 - i);
            #1;
            n_tests++;
            if (bus.ra !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_ra r%0d: got %h expected 0000", i, bus.ra);
            end
            n_tests++;
            if (bus.rt !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_rt r%0d: got %h expected 0000", 15 - i, bus.rt);
            end
        end
        n_tests++;
        if ({bus.ps, bus.ra_busy, bus.rt_busy, bus.ps_busy,
             bus.sb_overflow, bus.sb_underflow} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_status: got ps/busy/err %b expected 000000",
                     {bus.ps, bus.ra_busy, bus.rt_busy, bus.ps_busy,
                      bus.sb_overflow, bus.sb_underflow});
        end
        tick();
        wb_reg(4'd5, 16'hBEEF);
        tick();
        drive_idle();
        bus.ra_addr = 4'd5;
        #1;
        n_tests++;
        if (bus.ra !== 16'hBEEF || bus.sb_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL r5_written: got %h unf=%b expected beef unf=1",
                     bus.ra, bus.sb_underflow);
        end
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        #1;
        n_tests++;
        if (bus.ra !== 16'h0000 || bus.sb_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL r5_after_reset: got %h unf=%b expected 0000 unf=0",
                     bus.ra, bus.sb_underflow);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        wb_reg(4'd3, 16'h1234);
        bus.ra_addr = 4'd3;
        bus.rt_addr = 4'd3;
        #1;
        n_tests++;
        if (bus.ra !== 16'h1234 || bus.rt !== 16'h1234) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got ra=%h rt=%h expected 1234", bus.ra, bus.rt);
        end
        tick();
        drive_idle();
        bus.ra_addr = 4'd3;
        #1;
        n_tests++;
        if (bus.ra !== 16'h1234) begin
            n_fail++;
            $display("FAIL stored_read: got %h expected 1234", bus.ra);
        end
        wb_reg(4'd3, 16'hFFFF);
        bus.wb_valid = 1'b0;
        #1;
        n_tests++;
        if (bus.ra !== 16'h1234) begin
            n_fail++;
            $display("FAIL invalid_no_bypass: got %h expected 1234", bus.ra);
        end
        tick();
        drive_idle();
        bus.ra_addr = 4'd3;
        #1;
        n_tests++;
        if (bus.ra !== 16'h1234) begin
            n_fail++;
            $display("FAIL invalid_no_write: got %h expected 1234", bus.ra);
        end
    endtask

    task automatic test_ps();
        do_reset();
        bus.wb_valid = 1'b1; bus.wb_write_ps = 1'b1; bus.wb_ps = 1'b1;
        bus.wb_use_rw = 1'b0; bus.wb_rw_addr = 4'd4; bus.wb_data = 16'hAAAA;
        bus.ra_addr = 4'd4;
        #1;
        n_tests++;
        if (bus.ps !== 1'b1 || bus.ra !== 16'h0000) begin
            n_fail++;
            $display("FAIL ps_bypass: got ps=%b ra=%h expected ps=1 ra=0000", bus.ps, bus.ra);
        end
        tick();
        drive_idle();
        bus.ra_addr = 4'd4;
        #1;
        n_tests++;
        if (bus.ps !== 1'b1 || bus.ra !== 16'h0000) begin
            n_fail++;
            $display("FAIL ps_stored: got ps=%b ra=%h expected ps=1 ra=0000", bus.ps, bus.ra);
        end
    endtask

    task automatic test_busy();
        do_reset();
        iss_reg(4'd7);
        tick();
        iss_reg(4'd7);
        tick();
        drive_idle();
        bus.ra_addr = 4'd7;
        #1;
        n_tests++;
        if (bus.ra_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_issue: got %b expected 1", bus.ra_busy);
        end
        wb_reg(4'd7, 16'h1111);
        #1;
        n_tests++;
        if (bus.ra_busy !== 1'b1 || bus.ra !== 16'h1111) begin
            n_fail++;
            $display("FAIL busy_first_wb: got busy=%b ra=%h expected 1/1111", bus.ra_busy, bus.ra);
        end
        tick();
        wb_reg(4'd7, 16'h2222);
        bus.ra_addr = 4'd7;
        #1;
        n_tests++;
        if (bus.ra_busy !== 1'b0 || bus.ra !== 16'h2222) begin
            n_fail++;
            $display("FAIL busy_last_wb: got busy=%b ra=%h expected 0/2222", bus.ra_busy, bus.ra);
        end
        tick();
        drive_idle();
        bus.ra_addr = 4'd7;
        #1;
        n_tests++;
        if (bus.ra_busy !== 1'b0 || bus.sb_overflow !== 1'b0 || bus.sb_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_drained: got busy=%b ovf=%b unf=%b expected 0/0/0",
                     bus.ra_busy, bus.sb_overflow, bus.sb_underflow);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        iss_reg(4'd2);
        tick();
        iss_reg(4'd2);
        wb_reg(4'd2, 16'h0102);
        tick();
        drive_idle();
        bus.rt_addr = 4'd2;
        #1;
        n_tests++;
        if (bus.rt_busy !== 1'b1 || bus.sb_overflow !== 1'b0 || bus.sb_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL simultaneous_inc_dec: got busy=%b ovf=%b unf=%b expected 1/0/0",
                     bus.rt_busy, bus.sb_overflow, bus.sb_underflow);
        end
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            iss_reg(4'd2);
            tick();
            drive_idle();
            #1;
            n_tests++;
            if (bus.sb_overflow !== (k == 4)) begin
                n_fail++;
                $display("FAIL overflow_after_issue%0d: got %b expected %b",
                         k, bus.sb_overflow, (k == 4));
            end
        end
        tick();
        tick();
        n_tests++;
        if (bus.sb_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %b expected 1", bus.sb_overflow);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        wb_reg(4'd9, 16'h5A5A);
        tick();
        drive_idle();
        bus.ra_addr = 4'd9;
        #1;
        n_tests++;
        if (bus.ra !== 16'h5A5A || bus.sb_underflow !== 1'b1 || bus.sb_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_write: got ra=%h unf=%b ovf=%b expected 5a5a/1/0",
                     bus.ra, bus.sb_underflow, bus.sb_overflow);
        end
        tick();
        tick();
        n_tests++;
        if (bus.sb_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_sticky: got %b expected 1", bus.sb_underflow);
        end
        do_reset();
        #1;
        n_tests++;
        if (bus.sb_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_cleared: got %b expected 0", bus.sb_underflow);
        end
    endtask

    task automatic test_random();
        bit          wr, pw, hit_a, hit_t;
        logic [15:0] e_ra, e_rt;
        logic        e_ps, e_ra_busy, e_rt_busy, e_ps_busy;
        int          ca, ct;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            n_rst            = ($urandom_range(0, 99) != 0);
            bus.wb_valid     = 1'($urandom_range(0, 1));
            bus.wb_use_rw    = ($urandom_range(0, 3) != 0);
            bus.wb_rw_addr   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3))
                                                           : 4'($urandom_range(0, 15));
            bus.wb_data      = 16'($urandom);
            bus.wb_write_ps  = 1'($urandom_range(0, 1));
            bus.wb_ps        = 1'($urandom_range(0, 1));
            bus.iss_valid    = 1'($urandom_range(0, 1));
            bus.iss_use_rw   = ($urandom_range(0, 3) != 0);
            bus.iss_rw_addr  = 4'($urandom_range(0, 3));
            bus.iss_write_ps = 1'($urandom_range(0, 1));
            bus.ra_addr      = 4'($urandom_range(0, 4));
            bus.rt_addr      = ($urandom_range(0, 3) == 0) ? bus.ra_addr
                                                           : 4'($urandom_range(0, 15));
            #1;
            wr    = bus.wb_valid && bus.wb_use_rw;
            pw    = bus.wb_valid && bus.wb_write_ps;
            hit_a = wr && (bus.wb_rw_addr == bus.ra_addr);
            hit_t = wr && (bus.wb_rw_addr == bus.rt_addr);
            ca    = m_cnt[bus.ra_addr];
            ct    = m_cnt[bus.rt_addr];
            e_ra      = hit_a ? bus.wb_data : m_regs[bus.ra_addr];
            e_rt      = hit_t ? bus.wb_data : m_regs[bus.rt_addr];
            e_ps      = pw ? bus.wb_ps : m_ps;
            e_ra_busy = (ca > 0) && !(hit_a && ca == 1);
            e_rt_busy = (ct > 0) && !(hit_t && ct == 1);
            e_ps_busy = (m_ps_cnt > 0) && !(pw && m_ps_cnt == 1);
            n_tests++;
            if (bus.ra !== e_ra) begin
                n_fail++;
                $display("FAIL rand_ra cyc%0d: got %h expected %h", cyc, bus.ra, e_ra);
            end
            n_tests++;
            if (bus.rt !== e_rt) begin
                n_fail++;
                $display("FAIL rand_rt cyc%0d: got %h expected %h", cyc, bus.rt, e_rt);
            end
            n_tests++;
            if (bus.ps !== e_ps) begin
                n_fail++;
                $display("FAIL rand_ps cyc%0d: got %b expected %b", cyc, bus.ps, e_ps);
            end
            n_tests++;
            if ({bus.ra_busy, bus.rt_busy, bus.ps_busy} !== {e_ra_busy, e_rt_busy, e_ps_busy}) begin
                n_fail++;
                $display("FAIL rand_busy cyc%0d: got ra/rt/ps %b%b%b expected %b%b%b", cyc,
                         bus.ra_busy, bus.rt_busy, bus.ps_busy, e_ra_busy, e_rt_busy, e_ps_busy);
            end
            n_tests++;
            if ({bus.sb_overflow, bus.sb_underflow} !== {m_ovf, m_unf}) begin
                n_fail++;
                $display("FAIL rand_flags cyc%0d: got ovf/unf %b%b expected %b%b", cyc,
                         bus.sb_overflow, bus.sb_underflow, m_ovf, m_unf);
            end
            tick();
        end
        n_rst = 1'b1;
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_bypass();
        test_ps();
        test_busy();
        test_overflow();
        test_underflow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
